// File: rtl/load_store_aligner.sv
// Memory-stage load/store aligner: splits byte-addressed core accesses into
// word-aligned bus beats and right-justifies load bytes for the truncator.
module load_store_aligner #(
  parameter int BIT_COUNT = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemReq,
  input  logic                   MemWrite,
  input  logic [1:0]             MemSize,
  input  logic [BIT_COUNT-1:0]   MemAddr,
  input  logic [BIT_COUNT-1:0]   MemWriteData,
  output logic [BIT_COUNT-1:0]   LoadData,
  output logic                   LoadValid,
  output logic                   Stall,
  output logic                   BusReq,
  output logic                   BusWrite,
  output logic [BIT_COUNT-1:0]   BusAddr,
  output logic [BIT_COUNT-1:0]   BusWriteData,
  output logic [BIT_COUNT/8-1:0] BusByteEn,
  input  logic                   BusReady,
  input  logic                   BusReadValid,
  input  logic [BIT_COUNT-1:0]   BusReadData
);
  localparam int LANES = BIT_COUNT / 8;
  localparam int OFFW  = $clog2(LANES);

  typedef enum logic [2:0] {IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE} state_t;

  state_t                   state_q, state_d;
  logic                     write_q, write_d;
  logic                     split_q, split_d;
  logic [OFFW-1:0]          off_q, off_d;
  logic [LANES-1:0]         lmask_q, lmask_d;
  logic [BIT_COUNT-1:0]     addr1_q, addr1_d;
  logic [2*BIT_COUNT-1:0]   wdata2_q, wdata2_d;
  logic [2*LANES-1:0]       strobe2_q, strobe2_d;
  logic [BIT_COUNT-1:0]     rdata1_q, rdata1_d;
  logic [BIT_COUNT-1:0]     rdata2_q, rdata2_d;

  logic [1:0]               size_c;
  logic [OFFW-1:0]          off_c;
  logic [OFFW:0]            nbytes_c;
  logic                     split_c;
  logic [LANES-1:0]         lmask_c;
  logic [BIT_COUNT-1:0]     wmasked_c;
  logic [BIT_COUNT-1:0]     addr2_c;
  logic [BIT_COUNT-1:0]     merged_c;

  // Request decode; doubleword collapses to word on a 32-bit bus
  always_comb begin
    size_c    = (MemSize > 2'(OFFW)) ? 2'(OFFW) : MemSize;
    off_c     = MemAddr[OFFW-1:0];
    nbytes_c  = (OFFW+1)'(1) << size_c;
    split_c   = ({1'b0, off_c} + nbytes_c) > (OFFW+1)'(LANES);
    lmask_c   = '0;
    wmasked_c = '0;
    for (int i = 0; i < LANES; i++) begin
      lmask_c[i]           = (i < int'(nbytes_c));
      wmasked_c[8*i +: 8]  = lmask_c[i] ? MemWriteData[8*i +: 8] : 8'h00;
    end
  end

  // Next state and request/response capture
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    split_d   = split_q;
    off_d     = off_q;
    lmask_d   = lmask_q;
    addr1_d   = addr1_q;
    wdata2_d  = wdata2_q;
    strobe2_d = strobe2_q;
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    case (state_q)
      IDLE: begin
        if (MemReq) begin
          state_d   = REQ1;
          write_d   = MemWrite;
          split_d   = split_c;
          off_d     = off_c;
          lmask_d   = lmask_c;
          addr1_d   = {MemAddr[BIT_COUNT-1:OFFW], {OFFW{1'b0}}};
          wdata2_d  = {{BIT_COUNT{1'b0}}, wmasked_c} << {off_c, 3'b000};
          strobe2_d = {{LANES{1'b0}}, lmask_c} << off_c;
          // Non-split loads merge against zero upper data
          rdata2_d  = '0;
        end
      end
      REQ1: begin
        if (BusReady) begin
          if (!write_q)     state_d = WAIT1;
          else if (split_q) state_d = REQ2;
          else              state_d = DONE;
        end
      end
      WAIT1: begin
        if (BusReadValid) begin
          rdata1_d = BusReadData;
          state_d  = split_q ? REQ2 : DONE;
        end
      end
      REQ2: begin
        if (BusReady) state_d = write_q ? DONE : WAIT2;
      end
      WAIT2: begin
        if (BusReadValid) begin
          rdata2_d = BusReadData;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign addr2_c  = addr1_q + BIT_COUNT'(LANES);
  assign merged_c = BIT_COUNT'({rdata2_q, rdata1_q} >> {off_q, 3'b000});

  // Outputs are decoded from state so an async reset clears them at once
  always_comb begin
    Stall        = MemReq && (state_q != DONE);
    BusReq       = 1'b0;
    BusWrite     = 1'b0;
    BusAddr      = '0;
    BusWriteData = '0;
    BusByteEn    = '0;
    LoadData     = '0;
    LoadValid    = 1'b0;
    case (state_q)
      REQ1: begin
        BusReq       = 1'b1;
        BusWrite     = write_q;
        BusAddr      = addr1_q;
        BusByteEn    = strobe2_q[LANES-1:0];
        BusWriteData = write_q ? wdata2_q[BIT_COUNT-1:0] : '0;
      end
      REQ2: begin
        BusReq       = 1'b1;
        BusWrite     = write_q;
        BusAddr      = addr2_c;
        BusByteEn    = strobe2_q[2*LANES-1:LANES];
        BusWriteData = write_q ? wdata2_q[2*BIT_COUNT-1:BIT_COUNT] : '0;
      end
      DONE: begin
        LoadValid = 1'b1;
        for (int i = 0; i < LANES; i++) begin
          LoadData[8*i +: 8] = (!write_q && lmask_q[i]) ? merged_c[8*i +: 8] : 8'h00;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    write_q   <= write_d;
    split_q   <= split_d;
    off_q     <= off_d;
    lmask_q   <= lmask_d;
    addr1_q   <= addr1_d;
    wdata2_q  <= wdata2_d;
    strobe2_q <= strobe2_d;
    rdata1_q  <= rdata1_d;
    rdata2_q  <= rdata2_d;
  end

endmodule
